// File: rtl/palette_banked.sv
// Double-buffered colour palette: the front bank feeds pixels while software fills the back bank.
// A requested bank exchange is held off until the next frame boundary so a frame never mixes palettes.
//
// state   | meaning
// IDLE    | no exchange requested, swap_pending=0
// PENDING | exchange requested, waiting for frame_start, swap_pending=1
module palette_banked #(
   parameter int INDEX_W = 4,
   parameter int CHAN_W  = 4
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  wr_en,
   input  logic [INDEX_W-1:0]    wr_index,
   input  logic [3*CHAN_W-1:0]   wr_color,
   input  logic                  swap_req,
   input  logic                  frame_start,
   input  logic [INDEX_W-1:0]    rd_index,
   input  logic                  blank,
   output logic [CHAN_W-1:0]     red,
   output logic [CHAN_W-1:0]     green,
   output logic [CHAN_W-1:0]     blue,
   output logic                  swap_pending,
   output logic                  active_bank
);

   localparam int ENTRIES = 1 << INDEX_W;
   localparam int ENTRY_W = 3 * CHAN_W;

   typedef enum logic {IDLE = 1'b0, PENDING = 1'b1} state_t;

   state_t               state;
   logic [ENTRY_W-1:0]   mem [2][ENTRIES];
   logic                 back_bank;

   assign back_bank    = ~active_bank;
   assign swap_pending = (state == PENDING);

   // Reads and writes both use the pre-edge active_bank, so a write in the swap
   // cycle still lands in the bank that becomes the front.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < ENTRIES; i++)
               mem[b][i] <= '0;
         state       <= IDLE;
         active_bank <= 1'b0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
      end else begin
         if (wr_en)
            mem[back_bank][wr_index] <= wr_color;

         if (blank)
            {red, green, blue} <= '0;
         else
            {red, green, blue} <= mem[active_bank][rd_index];

         case (state)
            IDLE: begin
               if (swap_req)
                  state <= PENDING;
            end
            PENDING: begin
               if (frame_start) begin
                  state       <= IDLE;
                  active_bank <= ~active_bank;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_palette_banked.sv
// Directed bench for palette_banked: default 4/4 instance plus a 6/8 instance.
module tb_palette_banked;

   logic        Clk, Reset;
   logic        wr_en, swap_req, frame_start, blank;
   logic [3:0]  wr_index, rd_index;
   logic [11:0] wr_color;
   logic [3:0]  red, green, blue;
   logic        swap_pending, active_bank;
   logic [11:0] rgb;

   logic        w_wr_en, w_swap_req, w_frame_start, w_blank;
   logic [5:0]  w_wr_index, w_rd_index;
   logic [23:0] w_wr_color;
   logic [7:0]  w_red, w_green, w_blue;
   logic        w_swap_pending, w_active_bank;

   int n_cmp, n_err;

   assign rgb = {red, green, blue};

   palette_banked dut (
      .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_index(wr_index), .wr_color(wr_color),
      .swap_req(swap_req), .frame_start(frame_start), .rd_index(rd_index), .blank(blank),
      .red(red), .green(green), .blue(blue), .swap_pending(swap_pending), .active_bank(active_bank)
   );

   palette_banked #(.INDEX_W(6), .CHAN_W(8)) dut_wide (
      .Clk(Clk), .Reset(Reset), .wr_en(w_wr_en), .wr_index(w_wr_index), .wr_color(w_wr_color),
      .swap_req(w_swap_req), .frame_start(w_frame_start), .rd_index(w_rd_index), .blank(w_blank),
      .red(w_red), .green(w_green), .blue(w_blue), .swap_pending(w_swap_pending),
      .active_bank(w_active_bank)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
      n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL reset_pending got=%b exp=0", swap_pending); end
      n_cmp++; if (active_bank !== 1'b0) begin n_err++; $display("FAIL reset_bank got=%b exp=0", active_bank); end
      tick();
      Reset = 1'b0;
   endtask

   task automatic test_write_swap();
      wr_en = 1'b1; wr_index = 4'd3; wr_color = 12'hF84; rd_index = 4'd3;
      tick();
      wr_en = 1'b0;
      tick();
      n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL back_write_hidden got=%h exp=000", rgb); end
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL pending_set got=%b exp=1", swap_pending); end
      n_cmp++; if (active_bank !== 1'b0) begin n_err++; $display("FAIL bank_before_frame got=%b exp=0", active_bank); end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      n_cmp++; if (active_bank !== 1'b1) begin n_err++; $display("FAIL bank_after_swap got=%b exp=1", active_bank); end
      n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL pending_clear got=%b exp=0", swap_pending); end
      n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL swap_edge_pre_bank got=%h exp=000", rgb); end
      tick();
      n_cmp++; if (rgb !== 12'hF84) begin n_err++; $display("FAIL swap_read got=%h exp=F84", rgb); end
   endtask

   task automatic test_write_on_swap_edge();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      frame_start = 1'b1; wr_en = 1'b1; wr_index = 4'd5; wr_color = 12'h123;
      tick();
      frame_start = 1'b0; wr_en = 1'b0; rd_index = 4'd5;
      n_cmp++; if (active_bank !== 1'b0) begin n_err++; $display("FAIL swap_edge_bank got=%b exp=0", active_bank); end
      tick();
      n_cmp++; if (rgb !== 12'h123) begin n_err++; $display("FAIL write_on_swap_edge got=%h exp=123", rgb); end
      rd_index = 4'd3;
      tick();
      n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL old_front_hidden got=%h exp=000", rgb); end
   endtask

   task automatic test_request_absorb();
      swap_req = 1'b1;
      tick(); tick(); tick();
      swap_req = 1'b0;
      n_cmp++; if (swap_pending !== 1'b1) begin n_err++; $display("FAIL multi_req_pending got=%b exp=1", swap_pending); end
      frame_start = 1'b1;
      tick();
      n_cmp++; if (active_bank !== 1'b1) begin n_err++; $display("FAIL multi_req_one_toggle got=%b exp=1", active_bank); end
      tick();
      frame_start = 1'b0;
      n_cmp++; if (active_bank !== 1'b1) begin n_err++; $display("FAIL idle_frame_no_effect got=%b exp=1", active_bank); end
      n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL multi_req_no_queue got=%b exp=0", swap_pending); end
      swap_req = 1'b1; frame_start = 1'b1;
      tick();
      swap_req = 1'b0; frame_start = 1'b0;
      n_cmp++; if ({swap_pending, active_bank} !== 2'b11) begin n_err++; $display("FAIL idle_req_and_frame got=%b exp=11", {swap_pending, active_bank}); end
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      n_cmp++; if ({swap_pending, active_bank} !== 2'b00) begin n_err++; $display("FAIL deferred_swap got=%b exp=00", {swap_pending, active_bank}); end
   endtask

   task automatic test_blank();
      wr_en = 1'b1; wr_index = 4'd2; wr_color = 12'hABC;
      swap_req = 1'b1;
      tick();
      wr_en = 1'b0; swap_req = 1'b0; frame_start = 1'b1;
      tick();
      frame_start = 1'b0; rd_index = 4'd2; blank = 1'b1;
      tick();
      n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL blank_forces_zero got=%h exp=000", rgb); end
      blank = 1'b0;
      tick();
      n_cmp++; if (rgb !== 12'hABC) begin n_err++; $display("FAIL unblank_read got=%h exp=ABC", rgb); end
      blank = 1'b1;
      tick();
      n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL reblank got=%h exp=000", rgb); end
      blank = 1'b0; wr_en = 1'b1; wr_index = 4'd2; wr_color = 12'h555;
      tick();
      wr_en = 1'b0;
      tick();
      n_cmp++; if (rgb !== 12'hABC) begin n_err++; $display("FAIL back_write_isolated got=%h exp=ABC", rgb); end
      swap_req = 1'b1;
      tick();
      frame_start = 1'b1;
      tick();
      swap_req = 1'b0; frame_start = 1'b0;
      n_cmp++; if ({swap_pending, active_bank} !== 2'b00) begin n_err++; $display("FAIL req_and_frame_pending got=%b exp=00", {swap_pending, active_bank}); end
      tick();
      n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL req_absorbed got=%b exp=0", swap_pending); end
      n_cmp++; if (rgb !== 12'h555) begin n_err++; $display("FAIL swapped_back_contents got=%h exp=555", rgb); end
   endtask

   task automatic test_reset_midframe();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      n_cmp++; if ({swap_pending, rgb} !== {1'b1, 12'h555}) begin n_err++; $display("FAIL pre_reset_state got=%h exp=1555", {swap_pending, rgb}); end
      #2;
      Reset = 1'b1;
      #1;
      n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL async_reset_rgb got=%h exp=000", rgb); end
      n_cmp++; if ({swap_pending, active_bank} !== 2'b00) begin n_err++; $display("FAIL async_reset_ctrl got=%b exp=00", {swap_pending, active_bank}); end
      tick();
      Reset = 1'b0;
      for (int i = 0; i < 16; i++) begin
         rd_index = 4'(i);
         tick();
         n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL post_reset_read idx=%0d got=%h exp=000", i, rgb); end
      end
      n_cmp++; if (swap_pending !== 1'b0) begin n_err++; $display("FAIL swap_cancelled got=%b exp=0", swap_pending); end
   endtask

   task automatic test_wide();
      w_wr_en = 1'b1; w_wr_index = 6'd63; w_wr_color = 24'hFF8000; w_rd_index = 6'd63;
      tick();
      w_wr_en = 1'b0; w_swap_req = 1'b1;
      tick();
      w_swap_req = 1'b0; w_frame_start = 1'b1;
      n_cmp++; if ({w_red, w_green, w_blue} !== 24'h000000) begin n_err++; $display("FAIL wide_hidden got=%h exp=000000", {w_red, w_green, w_blue}); end
      tick();
      w_frame_start = 1'b0;
      n_cmp++; if (w_active_bank !== 1'b1) begin n_err++; $display("FAIL wide_bank got=%b exp=1", w_active_bank); end
      tick();
      n_cmp++; if ({w_red, w_green, w_blue} !== 24'hFF8000) begin n_err++; $display("FAIL wide_read got=%h exp=FF8000", {w_red, w_green, w_blue}); end
   endtask

   initial begin
      n_cmp = 0; n_err = 0;
      Reset = 1'b1;
      wr_en = 1'b0; wr_index = '0; wr_color = '0; swap_req = 1'b0; frame_start = 1'b0;
      rd_index = '0; blank = 1'b0;
      w_wr_en = 1'b0; w_wr_index = '0; w_wr_color = '0; w_swap_req = 1'b0; w_frame_start = 1'b0;
      w_rd_index = '0; w_blank = 1'b0;
      test_reset();
      test_write_swap();
      test_write_on_swap_edge();
      test_request_absorb();
      test_blank();
      test_reset_midframe();
      test_wide();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/palette_banked.md
PALETTE_BANKED -- requirements
Module: palette_banked

Interface
REQ-001 SHALL have parameter INDEX_W, default 4, giving the palette index width; entries = 2**INDEX_W.
REQ-002 SHALL have parameter CHAN_W, default 4, giving the per-channel colour width; entry width = 3*CHAN_W, packed {red, green, blue}.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wr_en, input, 1, write strobe for the back bank.
REQ-006 SHALL have port wr_index, input, INDEX_W, entry written when wr_en=1.
REQ-007 SHALL have port wr_color, input, 3*CHAN_W, data written {r,g,b}.
REQ-008 SHALL have port swap_req, input, 1, single-cycle request to exchange front/back banks at the next frame boundary.
REQ-009 SHALL have port frame_start, input, 1, single-cycle frame-boundary pulse.
REQ-010 SHALL have port rd_index, input, INDEX_W, pixel palette index.
REQ-011 SHALL have port blank, input, 1, pixel blanking flag aligned with rd_index.
REQ-012 SHALL have ports red, green, blue, output, CHAN_W each, registered pixel colour.
REQ-013 SHALL have port swap_pending, output, 1, high while a swap awaits frame_start.
REQ-014 SHALL have port active_bank, output, 1, bank currently displayed (front).

Function
REQ-015 SHALL hold two banks of 2**INDEX_W entries each, 3*CHAN_W bits per entry, in flip-flops.
REQ-016 SHALL read only from bank active_bank; SHALL write only to bank ~active_bank.
REQ-017 Read latency SHALL be exactly 1 cycle: rd_index/blank sampled at edge N drive red/green/blue after edge N.
REQ-018 Read at edge N SHALL use active_bank and bank contents as they were before edge N (pre-edge values).
REQ-019 blank sampled 1 SHALL force red=green=blue=0 on the following cycle regardless of index.
REQ-020 Write at edge N SHALL target the back bank as defined by active_bank before edge N, even if a swap occurs at edge N.
REQ-021 A write to the back bank SHALL never alter the displayed output before the next swap.
REQ-022 Swap control SHALL be a two-state machine: IDLE (swap_pending=0) and PENDING (swap_pending=1).
REQ-023 IDLE, swap_req=1 -> PENDING at next edge, regardless of frame_start in that cycle.
REQ-024 PENDING, frame_start=1 -> IDLE and active_bank toggles at that edge.
REQ-025 PENDING, swap_req=1 without frame_start SHALL have no further effect (requests do not queue).
REQ-026 PENDING, swap_req=1 and frame_start=1 same cycle -> single swap, return to IDLE; the request is absorbed.
REQ-027 frame_start in IDLE SHALL have no effect.
REQ-028 Swap SHALL NOT copy data; after a swap the back bank holds the previous front contents.
REQ-029 All indices SHALL address exactly 2**INDEX_W entries; no out-of-range case exists.

Reset
REQ-030 Reset=1 SHALL immediately, without a clock, set all entries of both banks to 0, active_bank=0, state IDLE (swap_pending=0), red=green=blue=0.
REQ-031 Reset asserted with a swap pending SHALL cancel it; a write in the cycle Reset deasserts on SHALL not be required to take effect.
REQ-032 First edge after Reset deasserts SHALL behave as normal operation.

Verification
REQ-033 Reset, write idx 3 = 0xF84 (back bank 1), rd_index=3 -> output stays 0x000; swap_req then frame_start -> active_bank=1, next-cycle output r=F,g=8,b=4.
REQ-034 Pending swap; wr_en idx 5 = 0x123 in same cycle as frame_start -> write lands in pre-swap back bank (1, now front); rd_index=5 next cycle -> 0x123.
REQ-035 swap_req asserted 3 times before frame_start -> exactly one toggle of active_bank; swap_req+frame_start both 1 in IDLE -> PENDING only, swap at following frame_start.
REQ-036 Front idx 2 = 0xABC, blank=1 with rd_index=2 -> output 0x000 next cycle; blank=0 -> 0xABC next cycle (1-cycle latency checked each cycle).
REQ-037 Reset asserted mid-frame with swap_pending=1 and nonzero outputs -> all outputs 0, swap_pending=0, active_bank=0 before the next edge; reads return 0x000 for all indices.
REQ-038 Parameter run INDEX_W=6, CHAN_W=8 -> write/swap/read idx 63 = 0xFF8000 returns r=FF,g=80,b=00.
